dmem_port_arbiter: RTL

Two-requester arbiter for the single data-memory port of the KGP_RISC core. It shares the BRAM between the CPU load/store path and the FPGA debug/readout port, which previously took the port through a raw `select` override. Each accepted request is registered onto the memory port, and read data is returned to the correct owner with a fixed latency. It also produces the CPU stall signal used to freeze the program counter while the CPU is waiting for the port.

---
 rtl/kgp_mem_pkg.sv | 19 +
 rtl/rr_arb2.sv | 42 ++++
 rtl/dmem_port_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/kgp_mem_pkg.sv
// rtl/kgp_mem_pkg.sv - shared data-memory widths, owner enum and read-tag type
package kgp_mem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    typedef struct packed {
        logic   rd;
        owner_t own;
    } tag_t;

    localparam tag_t TAG_IDLE = '{rd: 1'b0, own: OWN_CPU};

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input grant logic; round-robin when DMEM_ARB_RR_EN is defined, else fixed priority
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef DMEM_ARB_RR_EN
    // prio_q: 0 favours req0, 1 favours req1; flips to the loser after each grant
    logic prio_q, prio_d;

    always_comb begin
        gnt0   = req0 & (~req1 | ~prio_q);
        gnt1   = req1 & (~req0 |  prio_q);
        prio_d = prio_q;
        if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    // Fixed priority is stateless, so the clock and reset have no load here
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign gnt0 = req0;
    assign gnt1 = req1 & ~req0;
`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - CPU/debug arbiter for the shared data-memory port; DMEM_ARB_RR_EN selects round-robin
module dmem_port_arbiter
    import kgp_mem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_ena,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    logic              req_cpu, req_dbg;
    logic              ena_q, ena_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    tag_t              tag0_q, tag0_d;
    tag_t              tag1_q;

    // Grants are suppressed while reset is held so every output reads 0
    assign req_cpu = cpu_req & ~rst;
    assign req_dbg = dbg_req & ~rst;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (req_cpu),
        .req1 (req_dbg),
        .gnt0 (cpu_gnt),
        .gnt1 (dbg_gnt)
    );

    assign cpu_stall = req_cpu & ~cpu_gnt;

    always_comb begin
        ena_d  = cpu_gnt | dbg_gnt;
        wea_d  = 1'b0;
        addr_d = addr_q;
        din_d  = din_q;
        tag0_d = TAG_IDLE;
        if (cpu_gnt) begin
            wea_d  = cpu_we;
            addr_d = cpu_addr;
            din_d  = cpu_wdata;
            tag0_d = '{rd: ~cpu_we, own: OWN_CPU};
        end else if (dbg_gnt) begin
            wea_d  = dbg_we;
            addr_d = dbg_addr;
            din_d  = dbg_wdata;
            tag0_d = '{rd: ~dbg_we, own: OWN_DBG};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena_q  <= 1'b0;
            wea_q  <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            tag0_q <= TAG_IDLE;
            tag1_q <= TAG_IDLE;
        end else begin
            ena_q  <= ena_d;
            wea_q  <= wea_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            tag0_q <= tag0_d;
            tag1_q <= tag0_q;
        end
    end

    assign mem_ena  = ena_q;
    assign mem_wea  = wea_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;

    // Second tag stage lines up with mem_dout of the access granted two cycles earlier
    assign cpu_rvalid = tag1_q.rd & (tag1_q.own == OWN_CPU);
    assign dbg_rvalid = tag1_q.rd & (tag1_q.own == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_dout : '0;

endmodule
